reg_writeback_arbiter: RTL and testbench

- Writer-side front end for the 32x32 register file: merges single-cycle ALU results and buffered multi-cycle load completions into the file's single write port (`RegWrite`, `rd`, `write_data`).
- ALU results have priority; load completions wait in a FIFO; a starvation guard makes loads drain in bounded time.
- Optional scoreboard tracks destination registers with outstanding loads, so issue logic can detect RAW hazards before reading the file.

---
 rtl/reg_writeback_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_writeback_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results win, loads queue in a FIFO with a starvation guard.
// Optional destination scoreboard compiled in with `WB_SCOREBOARD_EN.
module reg_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
`ifdef WB_SCOREBOARD_EN
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy_mask,
`endif
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_rd_r   [DEPTH];
  logic [31:0]   fifo_data_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [SW-1:0] starve_r;

  logic          empty_s, full_s, force_s;
  logic          alu_take_s, deq_s, enq_s;
  logic [4:0]    head_rd_s;
  logic [31:0]   head_data_s;

  // Arbitration: a saturated starvation counter steals one cycle from the ALU for the FIFO head.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    force_s     = !empty_s && (starve_r == SW'(STARVE_LIMIT));
    alu_ready   = !reset && !force_s;
    mem_ready   = !reset && !full_s;
    alu_take_s  = alu_valid && alu_ready;
    deq_s       = !alu_take_s && !empty_s;
    enq_s       = mem_valid && mem_ready;
    head_rd_s   = fifo_rd_r[rd_ptr_r[AW-1:0]];
    head_data_s = fifo_data_r[rd_ptr_r[AW-1:0]];
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (enq_s) begin
      fifo_rd_r[wr_ptr_r[AW-1:0]]   <= mem_rd;
      fifo_data_r[wr_ptr_r[AW-1:0]] <= mem_data;
    end
  end

  // Pointers, starvation counter and the registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      starve_r   <= '0;
      RegWrite   <= 1'b0;
      rd         <= 5'd0;
      write_data <= 32'd0;
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (empty_s || deq_s) begin
        starve_r <= '0;
      end else begin
        starve_r <= starve_r + SW'(1);
      end
      // x0 entries are consumed and shown on rd/write_data, but never enable the write.
      if (alu_take_s) begin
        RegWrite   <= (alu_rd != 5'd0);
        rd         <= alu_rd;
        write_data <= alu_data;
      end else if (deq_s) begin
        RegWrite   <= (head_rd_s != 5'd0);
        rd         <= head_rd_s;
        write_data <= head_data_s;
      end else begin
        RegWrite   <= 1'b0;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_r, set_s, clr_s;

  // Scoreboard update terms; a same-cycle set overrides the clear so a new issue stays pending.
  always_comb begin
    set_s = 32'd0;
    clr_s = 32'd0;
    if (issue_valid && (issue_rd != 5'd0)) begin
      set_s[issue_rd] = 1'b1;
    end else begin
      set_s = 32'd0;
    end
    if (deq_s) begin
      clr_s[head_rd_s] = 1'b1;
    end else begin
      clr_s = 32'd0;
    end
  end

  // Scoreboard register; x0 can never be busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= ((busy_r & ~clr_s) | set_s) & 32'hFFFF_FFFE;
    end
  end

  assign busy_mask = busy_r;
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench for reg_writeback_arbiter: expected writes queued at drive time, popped at the write port.
module tb_reg_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rd;
  logic [31:0] alu_data, mem_data, write_data;
  logic        RegWrite;
`ifdef WB_SCOREBOARD_EN
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t pend_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  reg_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
`ifdef WB_SCOREBOARD_EN
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_mask(busy_mask),
`endif
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
`ifdef WB_SCOREBOARD_EN
    issue_valid = 1'b0; issue_rd = 5'd0;
`endif
  endtask

  // Write-port monitor: every enabled write must match the oldest expected entry.
  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_wr", 32'(RegWrite), 32'd0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check_eq("wb_rd", 32'(rd), 32'(e.rd));
        check_eq("wb_data", write_data, e.data);
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rst_regwrite", 32'(RegWrite), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_wdata", write_data, 32'd0);
    check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
`ifdef WB_SCOREBOARD_EN
    check_eq("rst_busy", busy_mask, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check_eq("rel_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("rel_mem_ready", 32'(mem_ready), 32'd1);

    // Single ALU write, one-cycle latency, then idle.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    check_eq("alu_ready_idle", 32'(alu_ready), 32'd1);
    sb_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick();
    alu_valid = 1'b0;
    check_eq("alu_lat_we", 32'(RegWrite), 32'd1);
    tick();
    check_eq("alu_after_we", 32'(RegWrite), 32'd0);

    // Single load with ALU idle: written two cycles after enqueue.
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    check_eq("ld_mem_ready", 32'(mem_ready), 32'd1);
    sb_q.push_back('{rd: 5'd3, data: 32'h33});
    tick();
    mem_valid = 1'b0;
    check_eq("ld_lat1_we", 32'(RegWrite), 32'd0);
    tick();
    check_eq("ld_lat2_we", 32'(RegWrite), 32'd1);
    check_eq("ld_lat2_rd", 32'(rd), 32'd3);
    tick();

    // Fill the FIFO while the ALU holds the port; loads drain in order afterwards.
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000_0000 + 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(i); mem_data = 32'(i) * 32'h11;
      check_eq("fill_mem_ready", 32'(mem_ready), 32'd1);
      check_eq("fill_alu_ready", 32'(alu_ready), 32'd1);
      sb_q.push_back('{rd: 5'(10 + i), data: 32'hA000_0000 + 32'(i)});
      pend_q.push_back('{rd: 5'(i), data: 32'(i) * 32'h11});
      tick();
    end
    alu_valid = 1'b0;
    mem_rd = 5'd31; mem_data = 32'h55;
    check_eq("full_mem_ready", 32'(mem_ready), 32'd0);
    while (pend_q.size() != 0) sb_q.push_back(pend_q.pop_front());
    tick();
    mem_valid = 1'b0;
    check_eq("after_full_ready", 32'(mem_ready), 32'd1);
    repeat (6) tick();

    // Starvation: ALU always valid, one load queued at c=0; exactly one stall at c=9.
    for (int c = 0; c <= 12; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(16 + (c % 8)); alu_data = 32'hB000_0000 + 32'(c);
      mem_valid = (c == 0); mem_rd = 5'd30; mem_data = 32'h3030;
      check_eq($sformatf("starve_ready_c%0d", c), 32'(alu_ready), (c == 9) ? 32'd0 : 32'd1);
      if (c == 9) sb_q.push_back('{rd: 5'd30, data: 32'h3030});
      else        sb_q.push_back('{rd: 5'(16 + (c % 8)), data: 32'hB000_0000 + 32'(c)});
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    // Write to x0: handshake completes, write enable stays low, data still shown.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    check_eq("x0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check_eq("x0_regwrite", 32'(RegWrite), 32'd0);
    check_eq("x0_wdata", write_data, 32'hFFFF_FFFF);
    tick();

`ifdef WB_SCOREBOARD_EN
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    check_eq("sb_set7", busy_mask, 32'h80);
    issue_rd = 5'd9;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    sb_q.push_back('{rd: 5'd9, data: 32'h99});
    tick();
    check_eq("sb_set9", busy_mask, 32'h280);
    issue_rd = 5'd0;
    mem_rd = 5'd7; mem_data = 32'h77;
    sb_q.push_back('{rd: 5'd7, data: 32'h77});
    tick();
    check_eq("sb_clr9_x0", busy_mask, 32'h80);
    mem_valid = 1'b0; issue_rd = 5'd7;
    tick();
    check_eq("sb_set_wins", busy_mask, 32'h80);
    issue_valid = 1'b0;
    tick();
    check_eq("sb_hold7", busy_mask, 32'h80);
`endif

    // Reset with three loads stuck behind the ALU: they must never be written.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'hC000_0000 + 32'(i);
      mem_valid = 1'b1; mem_rd = 5'(4 + i); mem_data = 32'hD000_0000 + 32'(i);
      sb_q.push_back('{rd: 5'(1 + i), data: 32'hC000_0000 + 32'(i)});
      tick();
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check_eq("mid_rst_regwrite", 32'(RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_mem_ready", 32'(mem_ready), 32'd1);
    check_eq("post_rst_alu_ready", 32'(alu_ready), 32'd1);
`ifdef WB_SCOREBOARD_EN
    check_eq("post_rst_busy", busy_mask, 32'd0);
`endif
    repeat (10) tick();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
